edge_detector_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-bit edge detector.
- Synchronises NUM_CH asynchronous inputs and detects rising, falling or both edges, selected at run time.
- Emits a registered one-cycle pulse per channel.
- Keeps a saturating per-channel edge counter with a sticky overflow flag.
- Sits between external/asynchronous status lines and the tester-side logic; counters are readable for bench scoreboarding.

---
 rtl/edge_detector_multi_if.sv | 25 ++
 rtl/edge_detector_multi.sv | 118 +++++++++++
 tb/tb_edge_detector_multi.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detector_multi_if.sv
// Bus between the asynchronous status lines and tester-side logic: channel inputs,
// run-time controls, and the per-channel pulse/counter results.
interface edge_detector_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_CH-1:0]           din;
  logic [1:0]                  mode;
  logic                        clr;
  logic [NUM_CH-1:0]           pulse;
  logic                        any_edge;
  logic [NUM_CH*CNT_WIDTH-1:0] edge_cnt;
  logic [NUM_CH-1:0]           overflow;
  logic                        armed;

  modport master (
    output din, mode, clr,
    input  pulse, any_edge, edge_cnt, overflow, armed
  );

  modport slave (
    input  din, mode, clr,
    output pulse, any_edge, edge_cnt, overflow, armed
  );
endinterface

// File: rtl/edge_detector_multi.sv
// Multi-channel synchronising edge detector with run-time edge selection,
// registered one-cycle pulses and saturating per-channel edge counters.
module edge_detector_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  edge_detector_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int                   WARM_W    = 3;
  localparam logic [WARM_W-1:0]    WARM_DONE = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0]                  prev_q, prev_d;
  logic [NUM_CH-1:0]                  pulse_q, pulse_d;
  logic [NUM_CH-1:0]                  ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                               any_q, any_d;
  logic                               armed_q, armed_d;
  logic [WARM_W-1:0]                  warm_q, warm_d;

  logic [NUM_CH-1:0] sync, rise, fall, det;

  always_comb begin
    sync_d[0] = bus.din;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign prev_d = sync;
  assign rise   = sync & ~prev_q;
  assign fall   = ~sync & prev_q;

  // Detection stays off until the synchroniser and prev register hold real samples.
  always_comb begin
    det = '0;
    if (armed_q) begin
      case (mode_e'(bus.mode))
        MODE_RISE: det = rise;
        MODE_FALL: det = fall;
        MODE_BOTH: det = rise | fall;
        default:   det = '0;
      endcase
    end
  end

  // NOTE: combinational blocks assign defaults first with blocking '=' so no path
  // leaves a variable unassigned (no latch) and later reads see the updated value.
  always_comb begin
    warm_d  = warm_q;
    armed_d = armed_q;
    if (!armed_q) begin
      warm_d = warm_q + WARM_W'(1);
      if (warm_d == WARM_DONE) armed_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (det[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        else                     ovf_d[i] = 1'b1;
      end
    end
  end

  assign pulse_d = det;
  assign any_d   = |det;

  // NOTE: every flop, synchroniser stages included, takes the async reset so a
  // din level held through reset cannot leak out as a stale edge; state uses '<='.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      armed_q <= 1'b0;
      warm_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
      warm_q  <= warm_d;
    end
  end

  assign bus.pulse    = pulse_q;
  assign bus.any_edge = any_q;
  assign bus.edge_cnt = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.armed    = armed_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Scoreboarded bench: each driven edge pushes its expected pulse cycle/mask; a
// negedge monitor pops and compares, tasks check counters and flags inline.
module tb_edge_detector_multi;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int CW   = 2;

  typedef struct {
    int             due;
    logic [NCH-1:0] mask;
  } sb_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   tests_run;
  int   tests_failed;
  bit   sb_en;
  sb_t  sb_q[$];

  edge_detector_multi_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) bus ();

  edge_detector_multi #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Pulse/any_edge monitor: pulses must appear exactly on scheduled cycles.
  always @(negedge clk) begin
    if (sb_en) begin
      automatic logic [NCH-1:0] exp_pulse = '0;
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_missed: pulse for cycle %0d mask %b never observed (now cycle %0d)",
                 sb_q[0].due, sb_q[0].mask, cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        exp_pulse = sb_q[0].mask;
        void'(sb_q.pop_front());
      end
      tests_run++;
      if (bus.pulse !== exp_pulse) begin
        tests_failed++;
        $display("FAIL pulse @cyc %0d: got %b expected %b", cyc, bus.pulse, exp_pulse);
      end
      tests_run++;
      if (bus.any_edge !== (|exp_pulse)) begin
        tests_failed++;
        $display("FAIL any_edge @cyc %0d: got %b expected %b", cyc, bus.any_edge, |exp_pulse);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive one channel level; when an edge is expected to be detected, schedule it.
  task automatic drive(input int ch, input logic val, input bit expect_pulse);
    sb_t e;
    bus.din[ch] = val;
    if (expect_pulse) begin
      e.due  = cyc + 1 + SYNC;
      e.mask = NCH'(1) << ch;
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return bus.edge_cnt[ch*CW +: CW];
  endfunction

  task automatic test_reset();
    bus.din  = 4'b1111;
    bus.mode = 2'b01;
    bus.clr  = 1'b0;
    #1 n_rst = 1'b0;
    sb_en = 1'b1;
    tick(2);
    tests_run++;
    if ({bus.armed, bus.pulse, bus.edge_cnt, bus.overflow} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: armed=%b pulse=%b cnt=%h ovf=%b expected all 0",
               bus.armed, bus.pulse, bus.edge_cnt, bus.overflow);
    end
    n_rst = 1'b1;
    for (int e = 1; e <= SYNC + 1; e++) begin
      tick(1);
      tests_run++;
      if (bus.armed !== (e == SYNC + 1)) begin
        tests_failed++;
        $display("FAIL warmup_armed edge %0d: got %b expected %b", e, bus.armed, e == SYNC + 1);
      end
    end
    tick(6);
    tests_run++;
    if (bus.edge_cnt !== '0) begin
      tests_failed++;
      $display("FAIL warmup_cnt: got %h expected 0", bus.edge_cnt);
    end
    // Return inputs low with detection off so later tests start clean.
    bus.mode = 2'b00;
    bus.din  = '0;
    tick(5);
    bus.mode = 2'b01;
  endtask

  task automatic test_rising_latency();
    drive(0, 1'b1, 1'b1);
    tick(2);
    tests_run++;
    if (bus.pulse[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_early: pulse[0] got %b expected 0", bus.pulse[0]);
    end
    tick(1);
    tests_run++;
    if (bus.pulse[0] !== 1'b1 || bus.any_edge !== 1'b1 || cnt_of(0) !== CW'(1)) begin
      tests_failed++;
      $display("FAIL latency_hit: pulse0=%b any=%b cnt0=%0d expected 1 1 1",
               bus.pulse[0], bus.any_edge, cnt_of(0));
    end
    tick(1);
    tests_run++;
    if (bus.pulse[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_one_cycle: pulse[0] got %b expected 0", bus.pulse[0]);
    end
    drive(0, 1'b0, 1'b0);
    tick(5);
    tests_run++;
    if (cnt_of(0) !== CW'(1)) begin
      tests_failed++;
      $display("FAIL rise_ignores_fall: cnt0 got %0d expected 1", cnt_of(0));
    end
  endtask

  task automatic test_modes();
    logic [1:0] modes [3];
    int         exp_cnt [3];
    modes   = '{2'b10, 2'b11, 2'b00};
    exp_cnt = '{1, 2, 0};
    for (int m = 0; m < 3; m++) begin
      pulse_clr();
      bus.mode = modes[m];
      drive(1, 1'b1, modes[m][0]);
      tick(5);
      drive(1, 1'b0, modes[m][1]);
      tick(5);
      tests_run++;
      if (cnt_of(1) !== CW'(exp_cnt[m]) || bus.overflow !== '0) begin
        tests_failed++;
        $display("FAIL mode_%b: cnt1=%0d ovf=%b expected %0d 0000",
                 modes[m], cnt_of(1), bus.overflow, exp_cnt[m]);
      end
    end
  endtask

  task automatic test_saturation();
    pulse_clr();
    bus.mode = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      drive(2, k[0], 1'b1);
      tick(4);
      tests_run++;
      if (cnt_of(2) !== CW'(k > 3 ? 3 : k) || bus.overflow[2] !== (k >= 4)) begin
        tests_failed++;
        $display("FAIL saturate edge %0d: cnt2=%0d ovf2=%b expected %0d %b",
                 k, cnt_of(2), bus.overflow[2], (k > 3 ? 3 : k), k >= 4);
      end
    end
    pulse_clr();
    tests_run++;
    if (cnt_of(2) !== '0 || bus.overflow[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL saturate_clr: cnt2=%0d ovf2=%b expected 0 0", cnt_of(2), bus.overflow[2]);
    end
  endtask

  task automatic test_clr_collision();
    drive(3, 1'b1, 1'b1);
    tick(4);
    drive(3, 1'b0, 1'b1);
    tick(4);
    tests_run++;
    if (cnt_of(3) !== CW'(2)) begin
      tests_failed++;
      $display("FAIL collision_setup: cnt3 got %0d expected 2", cnt_of(3));
    end
    drive(3, 1'b1, 1'b1);
    tick(2);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tests_run++;
    if (bus.pulse[3] !== 1'b1 || cnt_of(3) !== '0) begin
      tests_failed++;
      $display("FAIL clr_collision: pulse3=%b cnt3=%0d expected 1 0", bus.pulse[3], cnt_of(3));
    end
    tick(4);
  endtask

  task automatic test_back_to_back();
    sb_t e;
    pulse_clr();
    bus.mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      drive(0, ~bus.din[0], 1'b1);
      tick(1);
    end
    tick(4);
    tests_run++;
    if (cnt_of(0) !== CW'(3) || bus.overflow[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back: cnt0=%0d ovf0=%b expected 3 0", cnt_of(0), bus.overflow[0]);
    end
    // Simultaneous edges on two channels each count once.
    bus.din[2:1] = ~bus.din[2:1];
    e.due  = cyc + 1 + SYNC;
    e.mask = 4'b0110;
    sb_q.push_back(e);
    tick(5);
    tests_run++;
    if (cnt_of(1) !== CW'(1) || cnt_of(2) !== CW'(1) || cnt_of(3) !== '0) begin
      tests_failed++;
      $display("FAIL multi_channel: cnt1=%0d cnt2=%0d cnt3=%0d expected 1 1 0",
               cnt_of(1), cnt_of(2), cnt_of(3));
    end
  endtask

  task automatic test_reset_mid_run();
    #1 n_rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.armed, bus.pulse, bus.any_edge, bus.edge_cnt, bus.overflow} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: armed=%b pulse=%b any=%b cnt=%h ovf=%b expected all 0",
               bus.armed, bus.pulse, bus.any_edge, bus.edge_cnt, bus.overflow);
    end
    tick(2);
    n_rst = 1'b1;
    for (int e = 1; e <= SYNC + 1; e++) begin
      tick(1);
      tests_run++;
      if (bus.armed !== (e == SYNC + 1)) begin
        tests_failed++;
        $display("FAIL rewarm_armed edge %0d: got %b expected %b", e, bus.armed, e == SYNC + 1);
      end
    end
    tick(2);
    drive(3, ~bus.din[3], 1'b1);
    tick(4);
    tests_run++;
    if (cnt_of(3) !== CW'(1) || cnt_of(0) !== '0) begin
      tests_failed++;
      $display("FAIL resume_count: cnt3=%0d cnt0=%0d expected 1 0", cnt_of(3), cnt_of(0));
    end
  endtask

  initial begin
    cyc          = 0;
    tests_run    = 0;
    tests_failed = 0;
    sb_en        = 1'b0;
    n_rst        = 1'b1;
    bus.din      = '0;
    bus.mode     = 2'b00;
    bus.clr      = 1'b0;

    test_reset();
    test_rising_latency();
    test_modes();
    test_saturation();
    test_clr_collision();
    test_back_to_back();
    test_reset_mid_run();

    tick(2);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d expected pulses still pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
